// File: rtl/cla_seq_divider.sv
// Unsigned iterative restoring divider with a start/busy/done handshake.
// Each iteration is one trial subtraction done as add-with-complement, carry-in = 1.
module cla_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot_out;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dz;

  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_quot_out_nxt;
  logic [WIDTH-1:0] w_rem_out_nxt;
  logic             w_dz_nxt;

  // Held partial remainder stays below the divisor, so WIDTH bits suffice;
  // the shifted value needs one extra bit so the shifted-in bit never overflows.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_quo_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;

  // One restoring step: shift, trial subtract via complement add, keep or restore.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_quo_sh = {r_quo[WIDTH-2:0], 1'b0};
    w_trial  = w_rem_sh + ~{1'b0, r_div} + {{WIDTH{1'b0}}, 1'b1};
    if (w_trial[WIDTH] == 1'b0) begin
      w_rem_step = w_trial[WIDTH-1:0];
      w_quo_step = w_quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_rem_step = w_rem_sh[WIDTH-1:0];
      w_quo_step = w_quo_sh;
    end
  end

  // Next-state and next-output decode for the IDLE/CALC/DONE controller.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rem_nxt      = r_rem;
    w_quo_nxt      = r_quo;
    w_div_nxt      = r_div;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_quot_out_nxt = r_quot_out;
    w_rem_out_nxt  = r_rem_out;
    w_dz_nxt       = r_dz;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_div_nxt  = divisor;
          w_busy_nxt = 1'b1;
          if (divisor == {WIDTH{1'b0}}) begin
            w_state_nxt    = S_DONE;
            w_done_nxt     = 1'b1;
            w_quot_out_nxt = {WIDTH{1'b1}};
            w_rem_out_nxt  = dividend;
            w_dz_nxt       = 1'b1;
          end else begin
            w_state_nxt = S_CALC;
            w_rem_nxt   = {WIDTH{1'b0}};
            w_quo_nxt   = dividend;
            w_cnt_nxt   = {CW{1'b0}};
          end
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_CALC: begin
        w_rem_nxt = w_rem_step;
        w_quo_nxt = w_quo_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt    = S_DONE;
          w_done_nxt     = 1'b1;
          w_quot_out_nxt = w_quo_step;
          w_rem_out_nxt  = w_rem_step;
          w_dz_nxt       = 1'b0;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs; reset wins over everything.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_quo      <= {WIDTH{1'b0}};
      r_div      <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot_out <= {WIDTH{1'b0}};
      r_rem_out  <= {WIDTH{1'b0}};
      r_dz       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rem      <= w_rem_nxt;
      r_quo      <= w_quo_nxt;
      r_div      <= w_div_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_quot_out <= w_quot_out_nxt;
      r_rem_out  <= w_rem_out_nxt;
      r_dz       <= w_dz_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot_out;
  assign remainder = r_rem_out;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_cla_seq_divider.sv
// Bench for cla_seq_divider: directed scenarios, exhaustive 4-bit sweep and
// randomized runs against a plain-arithmetic reference (a/b, a%b).
module tb_cla_seq_divider;

  localparam int W = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  // Expected value of the held result registers
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  always #5 sys_clk = ~sys_clk;

  cla_seq_divider #(.WIDTH(W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample and drive both happen at the falling edge, away from the active edge
  task automatic tick;
    @(negedge sys_clk);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_q"}, quotient, last_q);
    check({tag, "_r"}, remainder, last_r);
    check({tag, "_z"}, div_zero, last_z);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < W + 4) begin
      tick;
      cyc++;
    end
  endtask

  // Issue one division from IDLE; noisy mode wiggles inputs and start while busy
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
    int           cyc;
    int           lat;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    if (b == 0) begin
      eq = {W{1'b1}}; er = a; ez = 1'b1; lat = 1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; lat = W + 1;
    end
    start = 1'b1; dividend = a; divisor = b;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < W + 4) begin
      check("busy_calc", busy, 1);
      check_held("hold_calc");
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      tick;
      cyc++;
    end
    check("latency", cyc, lat);
    check("busy_done", busy, 1);
    check("done", done, 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, ez);
    last_q = eq; last_r = er; last_z = ez;
    if (noisy) begin
      start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    end
    tick;
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check_held("hold_idle");
  endtask

  initial begin
    int cyc;
    sys_rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_held("rst");
    sys_rst = 1'b0;
    tick;

    run_div(4'd13, 4'd3, 1'b0);
    run_div(4'd15, 4'd1, 1'b0);
    run_div(4'd3,  4'd8, 1'b0);
    run_div(4'd7,  4'd0, 1'b0);
    run_div(4'd9,  4'd2, 1'b0);
    run_div(4'd12, 4'd5, 1'b1);
    run_div(4'd0,  4'd7, 1'b0);

    // Start held high: next operation accepted in the IDLE cycle after done
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    tick;
    wait_done(cyc);
    check("held_lat1", cyc, W + 1);
    check("held_q1", quotient, 2);
    check("held_r1", remainder, 2);
    dividend = 4'd9; divisor = 4'd2;
    tick;
    check("held_idle_busy", busy, 0);
    tick;
    check("held_accept_busy", busy, 1);
    check("held_accept_done", done, 0);
    start = 1'b0;
    wait_done(cyc);
    check("held_lat2", cyc, W + 1);
    check("held_q2", quotient, 4);
    check("held_r2", remainder, 1);
    check("held_z2", div_zero, 0);
    tick;
    last_q = 4'd4; last_r = 4'd1; last_z = 1'b0;

    // Reset during the third CALC cycle of 14/4
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    tick;
    start = 1'b0;
    tick;
    tick;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    last_q = '0; last_r = '0; last_z = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_held("midrst");
    run_div(4'd14, 4'd4, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(W'(a), W'(b), 1'b0);
      end
    end

    repeat (200) run_div(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
